control_ramp_bank: RTL and testbench

//  Multi-channel digital-to-analog control emulator. Turns digital plus/minus pairs into W-bit

---
 rtl/control_ramp_pkg.sv | 37 +++
 rtl/ramp_step_calc.sv | 94 +++++++++
 rtl/control_ramp_bank.sv | 149 ++++++++++++++
 tb/tb_control_ramp_bank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_ramp_pkg.sv
// Shared types and arithmetic helpers for the control ramp bank.
package control_ramp_pkg;

  // Per-channel behaviour when the digital inputs are released.
  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    CENTRE = 2'd1,
    DECAY  = 2'd2,
    WRAP   = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } fsm_t;

  // Last pressed direction; DirNone forces the next press to restart acceleration.
  typedef enum logic [1:0] {
    DirNone = 2'd0,
    DirUp   = 2'd1,
    DirDown = 2'd2
  } dir_t;

  function automatic int clamp_int(input int value, input int lo, input int hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

  // Move value by step toward target, landing exactly on it rather than overshooting.
  function automatic int approach(input int value, input int target, input int step);
    if (value > target) return ((value - step) < target) ? target : (value - step);
    if (value < target) return ((value + step) > target) ? target : (value + step);
    return value;
  endfunction

endpackage

// File: rtl/ramp_step_calc.sv
// Combinational next value / acceleration for one channel; time-shared across the scan.
// With ANALOG_OVERRIDE_EN defined, an enabled analog input replaces the digital update.
module ramp_step_calc
  import control_ramp_pkg::*;
#(
  parameter int unsigned     W         = 8,
  parameter int unsigned     STEP      = 2,
  parameter int unsigned     ACCEL_MAX = 3,
  parameter int unsigned     AccW      = 2,
  parameter logic [W-1:0]    CENTER    = 8'h80,
  parameter logic [W-1:0]    VMIN      = 8'h00,
  parameter logic [W-1:0]    VMAX      = 8'hFF
) (
  input  mode_t             mode_i,
  input  logic              plus_i,
  input  logic              minus_i,
  input  logic [W-1:0]      value_i,
  input  logic [AccW-1:0]   acc_i,
  input  dir_t              last_i,
`ifdef ANALOG_OVERRIDE_EN
  input  logic [W-1:0]      ana_i,
  input  logic              ana_en_i,
`endif
  output logic [W-1:0]      value_o,
  output logic [AccW-1:0]   acc_o,
  output dir_t              last_o
);

  localparam int StepI   = int'(STEP);
  localparam int CenterI = int'(CENTER);
  localparam int VminI   = int'(VMIN);
  localparam int VmaxI   = int'(VMAX);

  dir_t          dir;
  logic          both;
  logic [W+1:0]  delta;
  int            cur;
  int            nxt;

  // Decode direction, update acceleration, then apply the mode rule.
  always_comb begin
    both = plus_i & minus_i;
    dir  = DirNone;
    if (plus_i && !minus_i) begin
      dir = DirUp;
    end else if (minus_i && !plus_i) begin
      dir = DirDown;
    end

    acc_o  = acc_i;
    last_o = last_i;
    if (dir != DirNone) begin
      if (dir != last_i) begin
        acc_o = '0;
      end else if (acc_i < AccW'(ACCEL_MAX)) begin
        acc_o = acc_i + AccW'(1);
      end
      last_o = dir;
    end else if (both) begin
      // Both pressed cancels acceleration; the next press starts from the base step.
      acc_o  = '0;
      last_o = DirNone;
    end

    delta = (W + 2)'(STEP) << acc_o;
    cur   = int'(value_i);
    nxt   = cur;
    if (dir != DirNone) begin
      if (mode_i == WRAP) begin
        nxt = (dir == DirUp) ? (cur + int'(delta)) : (cur - int'(delta));
      end else begin
        nxt = clamp_int((dir == DirUp) ? (cur + int'(delta)) : (cur - int'(delta)),
                        VminI, VmaxI);
      end
    end else begin
      unique case (mode_i)
        CENTRE:  if (!both) nxt = approach(cur, CenterI, StepI);
        DECAY:   nxt = approach(cur, VminI, StepI);
        default: nxt = cur;
      endcase
    end
    // Truncation gives the modulo-2^W behaviour WRAP relies on.
    value_o = W'(nxt);

`ifdef ANALOG_OVERRIDE_EN
    if (ana_en_i) begin
      value_o = W'(clamp_int(int'($signed(ana_i)) + CenterI, VminI, VmaxI));
      acc_o   = '0;
      last_o  = DirNone;
    end
`endif
  end

endmodule

// File: rtl/control_ramp_bank.sv
// Multi-channel digital-to-analog control emulator: plus/minus pairs become W-bit positions.
// A strobe rise scans the channels one per cycle through a shared ramp_step_calc.
// Optional macro ANALOG_OVERRIDE_EN adds ana_i/ana_en for per-channel analog override.
module control_ramp_bank
  import control_ramp_pkg::*;
#(
  parameter int unsigned  CH        = 4,
  parameter int unsigned  W         = 8,
  parameter int unsigned  STEP      = 2,
  parameter int unsigned  ACCEL_MAX = 3,
  parameter logic [W-1:0] CENTER    = 8'h80,
  parameter logic [W-1:0] VMIN      = 8'h00,
  parameter logic [W-1:0] VMAX      = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              strobe,
  input  logic [2*CH-1:0]   mode_i,
  input  logic [CH-1:0]     plus_i,
  input  logic [CH-1:0]     minus_i,
`ifdef ANALOG_OVERRIDE_EN
  input  logic [W*CH-1:0]   ana_i,
  input  logic [CH-1:0]     ana_en,
`endif
  output logic [W*CH-1:0]   value_o,
  output logic              update_o,
  output logic              busy_o
);

  localparam int unsigned AccW = (ACCEL_MAX > 0) ? $clog2(ACCEL_MAX + 1) : 1;
  localparam int unsigned IdxW = (CH > 1) ? $clog2(CH) : 1;

  logic [2:0]              sync_q;
  logic                    rise;
  fsm_t                    state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    pending_q, pending_d;
  logic                    update_q, update_d;
  logic                    slot_we;

  logic [CH-1:0][1:0]      mode_arr;
  logic [CH-1:0][W-1:0]    value_q;
  logic [CH-1:0][AccW-1:0] acc_q;
  dir_t [CH-1:0]           last_q;

  logic [W-1:0]            calc_value;
  logic [AccW-1:0]         calc_acc;
  dir_t                    calc_last;

  assign mode_arr = mode_i;
  assign rise     = sync_q[1] & ~sync_q[2];

  // Strobe synchroniser and edge history; reset to ones so a strobe held high is not a rise.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[1:0], strobe};
    end
  end

  // Scan sequencing: start on rise or pending, one channel per cycle, pulse at the end.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    update_d  = 1'b0;
    slot_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise || pending_q) begin
          state_d   = SCAN;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      SCAN: begin
        slot_we = 1'b1;
        if (rise) pending_d = 1'b1;
        if (idx_q == IdxW'(CH - 1)) begin
          state_d  = IDLE;
          update_d = 1'b1;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, scan index, pending flag and update pulse.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      update_q  <= update_d;
    end
  end

  ramp_step_calc #(
    .W         (W),
    .STEP      (STEP),
    .ACCEL_MAX (ACCEL_MAX),
    .AccW      (AccW),
    .CENTER    (CENTER),
    .VMIN      (VMIN),
    .VMAX      (VMAX)
  ) u_calc (
    .mode_i   (mode_t'(mode_arr[idx_q])),
    .plus_i   (plus_i[idx_q]),
    .minus_i  (minus_i[idx_q]),
    .value_i  (value_q[idx_q]),
    .acc_i    (acc_q[idx_q]),
    .last_i   (last_q[idx_q]),
`ifdef ANALOG_OVERRIDE_EN
    .ana_i    (ana_i[W*idx_q +: W]),
    .ana_en_i (ana_en[idx_q]),
`endif
    .value_o  (calc_value),
    .acc_o    (calc_acc),
    .last_o   (calc_last)
  );

  // Per-channel state; reset value depends on the mode presented during reset.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      for (int c = 0; c < int'(CH); c++) begin
        value_q[c] <= (mode_arr[c] == DECAY) ? VMIN : CENTER;
        acc_q[c]   <= '0;
        last_q[c]  <= DirNone;
      end
    end else if (slot_we) begin
      value_q[idx_q] <= calc_value;
      acc_q[idx_q]   <= calc_acc;
      last_q[idx_q]  <= calc_last;
    end
  end

  assign value_o  = value_q;
  assign update_o = update_q;
  assign busy_o   = (state_q == SCAN);

endmodule

// File: tb/tb_control_ramp_bank.sv
// Directed bench for control_ramp_bank with a per-channel arithmetic model.
// Define ANALOG_OVERRIDE_EN for both RTL and bench to exercise the analog override.
module tb_control_ramp_bank;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic        strobe;
  logic [7:0]  mode_i;
  logic [3:0]  plus_i;
  logic [3:0]  minus_i;
  logic [31:0] value_o;
  logic        update_o;
  logic        busy_o;
`ifdef ANALOG_OVERRIDE_EN
  logic [31:0] ana_i;
  logic [3:0]  ana_en;
`endif

  control_ramp_bank dut (
    .clk_sys  (clk_sys),
    .RESET    (RESET),
    .strobe   (strobe),
    .mode_i   (mode_i),
    .plus_i   (plus_i),
    .minus_i  (minus_i),
`ifdef ANALOG_OVERRIDE_EN
    .ana_i    (ana_i),
    .ana_en   (ana_en),
`endif
    .value_o  (value_o),
    .update_o (update_o),
    .busy_o   (busy_o)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  bit settled = 1'b0;

  // Model state: value, acceleration, last direction (+1, -1, 0 = none).
  int m_val[4];
  int m_acc[4];
  int m_last[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_val[c]  = (mode_i[2*c +: 2] == 2'd2) ? 0 : 128;
      m_acc[c]  = 0;
      m_last[c] = 0;
    end
  endtask

  // One full scan, computed from the rules with plain integer arithmetic.
  task automatic model_scan();
    for (int c = 0; c < 4; c++) begin
      int  md;
      bit  p;
      bit  m;
      int  dir;
      int  d;
      int  v;
      md  = int'(mode_i[2*c +: 2]);
      p   = plus_i[c];
      m   = minus_i[c];
      dir = (p && !m) ? 1 : ((m && !p) ? -1 : 0);
`ifdef ANALOG_OVERRIDE_EN
      if (ana_en[c]) begin
        v = int'($signed(ana_i[8*c +: 8])) + 128;
        m_val[c]  = (v < 0) ? 0 : ((v > 255) ? 255 : v);
        m_acc[c]  = 0;
        m_last[c] = 0;
        continue;
      end
`endif
      if (dir != 0) begin
        m_acc[c]  = (dir == m_last[c]) ? ((m_acc[c] + 1 > 3) ? 3 : m_acc[c] + 1) : 0;
        m_last[c] = dir;
        d = 2 * (2 ** m_acc[c]);
        v = m_val[c] + dir * d;
        if (md == 3) m_val[c] = ((v % 256) + 256) % 256;
        else         m_val[c] = (v < 0) ? 0 : ((v > 255) ? 255 : v);
      end else begin
        if (p && m) begin
          m_acc[c]  = 0;
          m_last[c] = 0;
        end
        if (md == 1 && !(p && m)) begin
          if (m_val[c] > 128)      m_val[c] = (m_val[c] - 2 < 128) ? 128 : m_val[c] - 2;
          else if (m_val[c] < 128) m_val[c] = (m_val[c] + 2 > 128) ? 128 : m_val[c] + 2;
        end else if (md == 2) begin
          m_val[c] = (m_val[c] - 2 < 0) ? 0 : m_val[c] - 2;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    for (int c = 0; c < 4; c++) v[8*c +: 8] = 8'(m_val[c]);
    return v;
  endfunction

  // Whenever no scan is in flight the outputs must match the model exactly.
  always @(negedge clk_sys) begin
    if (settled) begin
      check("model_value", value_o, model_vec());
      check("idle_flags", {30'd0, update_o, busy_o}, 32'd0);
    end
  end

  // Single strobe pulse; expects busy for cycles 3..6 and update at cycle 7 after the pin.
  task automatic do_strobe(input string name);
    int busy_first;
    int busy_cnt;
    int upd_at;
    int upd_cnt;
    settled    = 1'b0;
    busy_first = -1;
    busy_cnt   = 0;
    upd_at     = -1;
    upd_cnt    = 0;
    @(negedge clk_sys);
    strobe = 1'b1;
    model_scan();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_sys);
      if (k == 2) strobe = 1'b0;
      if (busy_o) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = k;
      end
      if (update_o) begin
        upd_cnt++;
        upd_at = k;
      end
    end
    check({name, " busy_start"}, busy_first, 3);
    check({name, " busy_len"}, busy_cnt, 4);
    check({name, " update_at"}, upd_at, 7);
    check({name, " update_cnt"}, upd_cnt, 1);
    settled = 1'b1;
  endtask

  logic [3:0] tab_plus [16] = '{4'b1011, 4'b1011, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
                                4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1000,
                                4'b1000, 4'b0100, 4'b0000, 4'b0000};
  logic [3:0] tab_minus [16] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000,
                                 4'b0000, 4'b0010, 4'b0001, 4'b0001};
  // Hand-computed single-channel expectations after a given table step.
  int         lit_step [15] = '{0, 1, 2, 3, 4, 1, 2, 3, 4, 5, 9, 10, 11, 12, 10};
  int         lit_ch   [15] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 3, 3, 3, 3, 0};
  logic [7:0] lit_val  [15] = '{8'h82, 8'h86, 8'h8E, 8'h9E, 8'hAE, 8'h86, 8'h84, 8'h82,
                                8'h80, 8'h80, 8'hFE, 8'hFE, 8'h00, 8'h04, 8'hFF};

  initial begin
    int upd_cnt;
    int upd_first;
    int upd_last;
    int busy_cnt;
    RESET   = 1'b1;
    strobe  = 1'b0;
    mode_i  = 8'hE4;  // ch3 WRAP, ch2 DECAY, ch1 CENTRE, ch0 HOLD
    plus_i  = '0;
    minus_i = '0;
`ifdef ANALOG_OVERRIDE_EN
    ana_i  = '0;
    ana_en = '0;
`endif
    repeat (3) @(negedge clk_sys);
    RESET = 1'b0;
    model_reset();
    repeat (4) @(negedge clk_sys);
    check("T1 reset value", value_o, 32'h8000_8080);
    check("T1 reset update", {31'd0, update_o}, 32'd0);
    check("T1 reset busy", {31'd0, busy_o}, 32'd0);
    settled = 1'b1;

    // T2/T4: acceleration, clamp, wrap and both-pressed cancel.
    for (int s = 0; s < 16; s++) begin
      plus_i  = tab_plus[s];
      minus_i = tab_minus[s];
      do_strobe($sformatf("step%0d", s));
      for (int l = 0; l < 15; l++) begin
        if (lit_step[l] == s) begin
          check($sformatf("lit step%0d ch%0d", s, lit_ch[l]),
                {24'd0, value_o[8*lit_ch[l] +: 8]}, {24'd0, lit_val[l]});
        end
      end
    end
    check("table final", value_o, 32'h0400_80F9);

    // T5: three strobe rises, the last two during the first scan, collapse into one rescan.
    settled   = 1'b0;
    plus_i    = 4'b0001;
    minus_i   = 4'b0000;
    model_scan();
    model_scan();
    upd_cnt   = 0;
    upd_first = -1;
    upd_last  = -1;
    busy_cnt  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_sys);
      if (k > 0) begin
        if (busy_o) busy_cnt++;
        if (update_o) begin
          upd_cnt++;
          upd_last = k;
          if (upd_first < 0) upd_first = k;
        end
      end
      strobe = (k == 0 || k == 2 || k == 4);
    end
    check("T5 update_cnt", upd_cnt, 2);
    check("T5 update_first", upd_first, 7);
    check("T5 update_second", upd_last, 12);
    check("T5 busy_cycles", busy_cnt, 8);
    settled = 1'b1;
    @(negedge clk_sys);
    check("T5 value", value_o, 32'h0400_80FF);

    // T5: reset in the middle of a scan aborts it with no update pulse.
    settled  = 1'b0;
    upd_cnt  = 0;
    busy_cnt = 0;
    @(negedge clk_sys);
    strobe = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_sys);
      if (update_o) upd_cnt++;
      if (k >= 5 && busy_o) busy_cnt++;
      if (k == 1) strobe = 1'b0;
      if (k == 4) begin
        check("T5 busy before reset", {31'd0, busy_o}, 32'd1);
        RESET = 1'b1;
      end
      if (k == 5) begin
        RESET = 1'b0;
        model_reset();
      end
    end
    check("T5 abort update_cnt", upd_cnt, 0);
    check("T5 abort busy", busy_cnt, 0);
    check("T5 abort value", value_o, 32'h8000_8080);
    settled = 1'b1;
    do_strobe("post-reset");
    check("post-reset acc cleared", {24'd0, value_o[7:0]}, 32'h82);

`ifdef ANALOG_OVERRIDE_EN
    // T6: analog override on ch1/ch2, then release back to the digital modes.
    plus_i  = '0;
    minus_i = '0;
    ana_en  = 4'b0110;
    ana_i   = 32'h0080_0500;
    do_strobe("T6 ana1");
    check("T6 ch2 min", {24'd0, value_o[23:16]}, 32'h00);
    check("T6 ch1 0x85", {24'd0, value_o[15:8]}, 32'h85);
    ana_en = 4'b0100;
    ana_i  = 32'h007F_0000;
    do_strobe("T6 ana2");
    check("T6 ch2 max", {24'd0, value_o[23:16]}, 32'hFF);
    check("T6 ch1 centre 83", {24'd0, value_o[15:8]}, 32'h83);
    ana_en = 4'b0000;
    do_strobe("T6 rel1");
    check("T6 ch2 decay", {24'd0, value_o[23:16]}, 32'hFD);
    check("T6 ch1 centre 81", {24'd0, value_o[15:8]}, 32'h81);
    do_strobe("T6 rel2");
    check("T6 ch1 centre land", {24'd0, value_o[15:8]}, 32'h80);
    do_strobe("T6 rel3");
    check("T6 ch1 centre stay", {24'd0, value_o[15:8]}, 32'h80);
`endif

    settled = 1'b0;
    @(negedge clk_sys);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
